// File: rtl/sdram_fifo_ctrl_if.sv
// Bus bundle for sdram_fifo_ctrl: user FIFO ports plus the SDRAM controller
// burst write/read ports. The slave modport is the bridge's view.
interface sdram_fifo_ctrl_if;
  logic        i_init_done;
  logic        i_wr_en;
  logic [15:0] i_wr_data;
  logic [23:0] i_wr_b_addr;
  logic [23:0] i_wr_e_addr;
  logic        i_rd_en;
  logic [15:0] o_rd_data;
  logic [23:0] i_rd_b_addr;
  logic [23:0] i_rd_e_addr;
  logic        i_rd_valid;
  logic        o_wr_full;
  logic        o_rd_empty;
  logic        o_sdram_wr_req;
  logic [23:0] o_sdram_wr_addr;
  logic [9:0]  o_sdram_wr_burst_len;
  logic [15:0] o_sdram_wr_data;
  logic        i_sdram_wr_ack;
  logic        o_sdram_rd_req;
  logic [23:0] o_sdram_rd_addr;
  logic [9:0]  o_sdram_rd_burst_len;
  logic [15:0] i_sdram_rd_data;
  logic        i_sdram_rd_ack;

  modport slave (
    input  i_init_done, i_wr_en, i_wr_data, i_wr_b_addr, i_wr_e_addr,
           i_rd_en, i_rd_b_addr, i_rd_e_addr, i_rd_valid,
           i_sdram_wr_ack, i_sdram_rd_data, i_sdram_rd_ack,
    output o_rd_data, o_wr_full, o_rd_empty,
           o_sdram_wr_req, o_sdram_wr_addr, o_sdram_wr_burst_len, o_sdram_wr_data,
           o_sdram_rd_req, o_sdram_rd_addr, o_sdram_rd_burst_len
  );

  modport master (
    output i_init_done, i_wr_en, i_wr_data, i_wr_b_addr, i_wr_e_addr,
           i_rd_en, i_rd_b_addr, i_rd_e_addr, i_rd_valid,
           i_sdram_wr_ack, i_sdram_rd_data, i_sdram_rd_ack,
    input  o_rd_data, o_wr_full, o_rd_empty,
           o_sdram_wr_req, o_sdram_wr_addr, o_sdram_wr_burst_len, o_sdram_wr_data,
           o_sdram_rd_req, o_sdram_rd_addr, o_sdram_rd_burst_len
  );
endinterface

// File: rtl/sdram_fifo_ctrl.sv
// SDRAM burst bridge: show-ahead write/read FIFOs feeding a fair write/read
// burst requester with per-direction wrapping region addresses.
module sdram_fifo_ctrl #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input logic              i_sysclk,
  input logic              i_sysrst_n,
  sdram_fifo_ctrl_if.slave bus
);
  localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
  localparam logic [23:0]   STEP_C  = 24'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t        state;
  logic          last_rd, ack_seen, wr_pend_q, rd_pend_q;
  logic          wr_pend, rd_pend, wr_done, rd_done;
  logic [23:0]   wr_sum, rd_sum;

  logic [15:0]   wf_mem [FIFO_DEPTH];
  logic [AW-1:0] wf_wp, wf_rp;
  logic [CW-1:0] wf_cnt, wf_cnt_nxt;
  logic          wf_push, wf_pop;

  logic [15:0]   rf_mem [FIFO_DEPTH];
  logic [AW-1:0] rf_wp, rf_rp;
  logic [CW-1:0] rf_cnt, rf_cnt_nxt;
  logic          rf_push, rf_pop;

  assign wf_push = bus.i_wr_en && !bus.o_wr_full;
  assign wf_pop  = bus.i_sdram_wr_ack && (wf_cnt != '0);
  assign rf_push = bus.i_sdram_rd_ack && (rf_cnt != DEPTH_C);
  assign rf_pop  = bus.i_rd_en && !bus.o_rd_empty;

  always_comb begin
    wf_cnt_nxt = wf_cnt;
    rf_cnt_nxt = rf_cnt;
    if (wf_push && !wf_pop) wf_cnt_nxt = wf_cnt + CW'(1);
    else if (!wf_push && wf_pop) wf_cnt_nxt = wf_cnt - CW'(1);
    if (rf_push && !rf_pop) rf_cnt_nxt = rf_cnt + CW'(1);
    else if (!rf_push && rf_pop) rf_cnt_nxt = rf_cnt - CW'(1);
  end

  // Storage is cleared on reset so the show-ahead heads read zero afterwards.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        wf_mem[AW'(i)] <= '0;
        rf_mem[AW'(i)] <= '0;
      end
      wf_wp          <= '0;
      wf_rp          <= '0;
      wf_cnt         <= '0;
      rf_wp          <= '0;
      rf_rp          <= '0;
      rf_cnt         <= '0;
      bus.o_wr_full  <= 1'b0;
      bus.o_rd_empty <= 1'b1;
    end else begin
      if (wf_push) begin
        wf_mem[wf_wp] <= bus.i_wr_data;
        wf_wp         <= wf_wp + AW'(1);
      end
      if (wf_pop) wf_rp <= wf_rp + AW'(1);
      if (rf_push) begin
        rf_mem[rf_wp] <= bus.i_sdram_rd_data;
        rf_wp         <= rf_wp + AW'(1);
      end
      if (rf_pop) rf_rp <= rf_rp + AW'(1);
      wf_cnt         <= wf_cnt_nxt;
      rf_cnt         <= rf_cnt_nxt;
      bus.o_wr_full  <= (wf_cnt_nxt == DEPTH_C);
      bus.o_rd_empty <= (rf_cnt_nxt == '0);
    end
  end

  assign bus.o_sdram_wr_data      = wf_mem[wf_rp];
  assign bus.o_rd_data            = rf_mem[rf_rp];
  assign bus.o_sdram_wr_burst_len = 10'(BURST_LEN);
  assign bus.o_sdram_rd_burst_len = 10'(BURST_LEN);

  assign wr_pend = bus.i_init_done && (wf_cnt >= BURST_C);
  assign rd_pend = bus.i_init_done && bus.i_rd_valid && ((DEPTH_C - rf_cnt) >= BURST_C);

  // A burst ends on the first idle-ack cycle after at least one ack was seen.
  assign wr_done = (state == WR) && ack_seen && !bus.i_sdram_wr_ack;
  assign rd_done = (state == RD) && ack_seen && !bus.i_sdram_rd_ack;
  assign wr_sum  = bus.o_sdram_wr_addr + STEP_C;
  assign rd_sum  = bus.o_sdram_rd_addr + STEP_C;

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state              <= IDLE;
      bus.o_sdram_wr_req <= 1'b0;
      bus.o_sdram_rd_req <= 1'b0;
      last_rd            <= 1'b1;
      ack_seen           <= 1'b0;
      wr_pend_q          <= 1'b0;
      rd_pend_q          <= 1'b0;
    end else begin
      wr_pend_q <= wr_pend;
      rd_pend_q <= rd_pend;
      case (state)
        IDLE: begin
          ack_seen <= 1'b0;
          if (bus.i_init_done && wr_pend_q && (!rd_pend_q || last_rd)) begin
            state              <= WR;
            bus.o_sdram_wr_req <= 1'b1;
            last_rd            <= 1'b0;
          end else if (bus.i_init_done && rd_pend_q) begin
            state              <= RD;
            bus.o_sdram_rd_req <= 1'b1;
            last_rd            <= 1'b1;
          end
        end
        WR: begin
          if (bus.i_sdram_wr_ack) begin
            bus.o_sdram_wr_req <= 1'b0;
            ack_seen           <= 1'b1;
          end else if (wr_done) begin
            state <= IDLE;
          end
        end
        RD: begin
          if (bus.i_sdram_rd_ack) begin
            bus.o_sdram_rd_req <= 1'b0;
            ack_seen           <= 1'b1;
          end else if (rd_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      bus.o_sdram_wr_addr <= '0;
      bus.o_sdram_rd_addr <= '0;
    end else if (!bus.i_init_done) begin
      bus.o_sdram_wr_addr <= bus.i_wr_b_addr;
      bus.o_sdram_rd_addr <= bus.i_rd_b_addr;
    end else begin
      if (wr_done) bus.o_sdram_wr_addr <= (wr_sum >= bus.i_wr_e_addr) ? bus.i_wr_b_addr : wr_sum;
      if (rd_done) bus.o_sdram_rd_addr <= (rd_sum >= bus.i_rd_e_addr) ? bus.i_rd_b_addr : rd_sum;
    end
  end
endmodule
